p2s_tx: RTL and testbench
=========================

P2S_TX -- requirements
Module: p2s_tx

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 2: sck half-period in clk cycles, legal range 1..255.
REQ-002 SHALL provide parameter CS_GAP, default 4: cs-high cycles between words, legal range 1..255.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on posedge clk.
REQ-004 SHALL have port rstn, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port start, input, 1: frame request; accepted when start&&ready.
REQ-006 SHALL have port sample_a, input, 14: first data word, sampled on accept.
REQ-007 SHALL have port sample_b, input, 14: second data word, sampled on accept.
REQ-008 SHALL have port ready, output, 1: high only in IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse at frame end.
REQ-010 SHALL have port sck, output, 1: serial clock; idle low.
REQ-011 SHALL have port mosi, output, 1: serial data, MSB first.
REQ-012 SHALL have port cs, output, 1: word strobe; idle high, low while a word shifts.

Function
REQ-013 Frame SHALL be three 14-bit words in order: header 14'h0FFF, sample_a, sample_b.
REQ-014 FSM states SHALL be IDLE, SHIFT, GAP; IDLE->SHIFT on accept, SHIFT->GAP after the 14th sck high phase, GAP->SHIFT after CS_GAP cycles if words remain, otherwise GAP->IDLE.
REQ-015 Cycle after accept: cs=0, sck=0, mosi=header bit13.
REQ-016 Each bit SHALL be CLK_DIV cycles sck low, then CLK_DIV cycles sck high; mosi SHALL change only on the cycle sck goes low or cs falls, so it is stable across every sck rising edge.
REQ-017 After the 14th high phase: sck=0 and cs=1 in the same cycle; cs held high exactly CS_GAP cycles; mosi=0 in GAP.
REQ-018 Word period SHALL be 28*CLK_DIV+CS_GAP cycles; frame length from first cs fall to done SHALL be 3*(28*CLK_DIV+CS_GAP) cycles.
REQ-019 done and ready SHALL assert in the same cycle the FSM re-enters IDLE; a new start in that cycle SHALL be accepted.
REQ-020 start while ready=0 SHALL be ignored; sample inputs SHALL be ignored except on accept.
REQ-021 Exactly 14 sck rising edges SHALL occur per cs-low window; no sck edge while cs=1.

Reset
REQ-022 With rstn=0 at a clk edge: state=IDLE, sck=0, cs=1, mosi=0, done=0, ready=1, counters and shift register cleared, next cycle.
REQ-023 Reset mid-frame SHALL abort without completing the word and without a done pulse.

Configuration
REQ-024 Macro P2S_OFFSET_EN: when defined, transmitted words SHALL be sample_a+1395 and sample_b+1568, modulo 2^14; when undefined, samples SHALL be sent unmodified. The header SHALL never be offset in either case.

Structure
REQ-025 Package p2s_pkg SHALL hold WORD_W=14, HEADER_WORD=14'h0FFF, OFFSET_A=1395, OFFSET_B=1568, and the FSM state enum.
REQ-026 Sub-module p2s_sck_div SHALL generate sck and the per-phase enable from CLK_DIV.

Verification
REQ-027 Reset, no start -> sck=0, cs=1, mosi=0, ready=1, done=0 held for 100 cycles.
REQ-028 Defaults, sample_a=14'h1234, sample_b=14'h2ABC, offset macro off -> a bit-sampling monitor on sck rising edges decodes 0FFF, 1234, 2ABC; done exactly 180 cycles after first cs fall.
REQ-029 P2S_OFFSET_EN defined, sample_a=14'h3FFF, sample_b=0 -> decoded words 0FFF, 0572, 0620.
REQ-030 start pulsed at cycles 10 and 50 of a frame -> second start ignored; one frame only; start in the done cycle -> back-to-back frame with cs rising/falling per REQ-017.
REQ-031 rstn low for one cycle mid sample_a -> next cycle cs=1, sck=0, ready=1, no done; new frame then completes normally.
REQ-032 CLK_DIV=1, CS_GAP=1 -> sck toggles every cycle, 14 rising edges per word, frame = 87 cycles.

Source files
------------

// File: rtl/p2s_pkg.sv
// Shared constants and FSM state type for the p2s_tx serial frame transmitter.
package p2s_pkg;

  localparam int unsigned WORD_W          = 14;
  localparam int unsigned BIT_W           = 4;
  localparam int unsigned WORD_CNT_W      = 2;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned WORDS_PER_FRAME = 3;

  localparam logic [WORD_W-1:0] HEADER_WORD = 14'h0FFF;
  localparam int unsigned       OFFSET_A    = 1395;
  localparam int unsigned       OFFSET_B    = 1568;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

endpackage

// File: rtl/p2s_sck_div.sv
// Serial clock generator: sck half-period of CLK_DIV clk cycles while en is high,
// held low with its phase counter cleared otherwise.
module p2s_sck_div
  import p2s_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic sck,
  output logic phase_end_c
);

  logic [CNT_W-1:0] cnt;

  // Last clk cycle of the current sck phase.
  assign phase_end_c = en && (cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rstn || !en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (phase_end_c) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/p2s_tx.sv
// Three-word serial frame transmitter (header, sample_a, sample_b), MSB first.
// Build macro P2S_OFFSET_EN adds fixed offsets to the sample words before sending.
module p2s_tx
  import p2s_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [WORD_W-1:0] sample_a,
  input  logic [WORD_W-1:0] sample_b,
  output logic              ready,
  output logic              done,
  output logic              sck,
  output logic              mosi,
  output logic              cs
);

  state_t                state_q, state_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [WORD_CNT_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]      gap_q, gap_d;
  logic [WORD_W-1:0]     shreg_q, shreg_d;
  logic [WORD_W-1:0]     a_q, a_d, b_q, b_d;
  logic                  cs_q, cs_d, mosi_q, mosi_d, done_q, done_d, ready_q, ready_d;
  logic [WORD_W-1:0]     word_a_c, word_b_c, next_word_c;
  logic                  phase_end_c;

`ifdef P2S_OFFSET_EN
  assign word_a_c = sample_a + WORD_W'(OFFSET_A);
  assign word_b_c = sample_b + WORD_W'(OFFSET_B);
`else
  assign word_a_c = sample_a;
  assign word_b_c = sample_b;
`endif

  assign next_word_c = (word_q == WORD_CNT_W'(0)) ? a_q : b_q;

  p2s_sck_div #(.CLK_DIV(CLK_DIV)) u_sck_div (
    .clk         (clk),
    .rstn        (rstn),
    .en          (state_q == SHIFT),
    .sck         (sck),
    .phase_end_c (phase_end_c)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      bit_q   <= '0;
      word_q  <= '0;
      gap_q   <= '0;
      shreg_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      gap_q   <= gap_d;
      shreg_q <= shreg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    word_d  = word_q;
    gap_d   = gap_q;
    shreg_d = shreg_q;
    a_d     = a_q;
    b_d     = b_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_d     = word_a_c;
          b_d     = word_b_c;
          shreg_d = HEADER_WORD;
          mosi_d  = HEADER_WORD[WORD_W-1];
          cs_d    = 1'b0;
          bit_d   = '0;
          word_d  = '0;
          ready_d = 1'b0;
        end
      end
      SHIFT: begin
        // Data advances only as sck falls, keeping mosi stable over each rising edge.
        if (phase_end_c && sck) begin
          if (bit_q == BIT_W'(WORD_W - 1)) begin
            state_d = GAP;
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            gap_d   = '0;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
            mosi_d  = shreg_q[WORD_W-2];
          end
        end
      end
      GAP: begin
        if (gap_q == CNT_W'(CS_GAP - 1)) begin
          if (word_q == WORD_CNT_W'(WORDS_PER_FRAME - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            ready_d = 1'b1;
          end else begin
            state_d = SHIFT;
            word_d  = word_q + WORD_CNT_W'(1);
            shreg_d = next_word_c;
            mosi_d  = next_word_c[WORD_W-1];
            cs_d    = 1'b0;
            bit_d   = '0;
          end
        end else begin
          gap_d = gap_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign mosi  = mosi_q;
  assign cs    = cs_q;

endmodule

// File: tb/tb_p2s_tx.sv
// Self-checking bench for p2s_tx: default-parameter instance plus a CLK_DIV=1/CS_GAP=1 instance.
module tb_p2s_tx;

  localparam int D0 = 2, G0 = 4, D1 = 1, G1 = 1;
  localparam int FRAME0 = 3 * (28 * D0 + G0);
  localparam int FRAME1 = 3 * (28 * D1 + G1);

  logic clk = 1'b0, rstn = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [13:0] sa0 = '0, sb0 = '0, sa1 = '0, sb1 = '0;
  logic ready0, done0, sck0, mosi0, cs0;
  logic ready1, done1, sck1, mosi1, cs1;

  int n_checks = 0, n_fail = 0;

  p2s_tx dut0 (.clk(clk), .rstn(rstn), .start(start0), .sample_a(sa0), .sample_b(sb0),
               .ready(ready0), .done(done0), .sck(sck0), .mosi(mosi0), .cs(cs0));
  p2s_tx #(.CLK_DIV(D1), .CS_GAP(G1)) dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .sample_a(sa1), .sample_b(sb1),
    .ready(ready1), .done(done1), .sck(sck1), .mosi(mosi1), .cs(cs1));

  always #5 clk = ~clk;

  // Reference: what a receiver should decode for word k of a frame.
  function automatic logic [13:0] exp_word(input int k, input logic [13:0] a, input logic [13:0] b);
    int v;
    if (k == 0) return 14'h0FFF;
    v = (k == 1) ? int'(a) : int'(b);
`ifdef P2S_OFFSET_EN
    v = (v + ((k == 1) ? 1395 : 1568)) % 16384;
`endif
    return 14'(v);
  endfunction

  // Receiver-side monitor state: decodes bits on sck rising edges within a cs-low window.
  typedef struct {
    logic psck, pcs, pmosi;
    logic [13:0] sh;
    int bits, hi, edge_viol, mosi_viol;
  } mon_t;

  mon_t m0 = '{psck: 1'b0, pcs: 1'b1, pmosi: 1'b0, sh: '0, bits: 0, hi: 0, edge_viol: 0, mosi_viol: 0};
  mon_t m1 = '{psck: 1'b0, pcs: 1'b1, pmosi: 1'b0, sh: '0, bits: 0, hi: 0, edge_viol: 0, mosi_viol: 0};
  logic [13:0] words0[$], words1[$];
  int bits0[$], bits1[$], gaps0[$], gaps1[$];

  function automatic void mon_step(inout mon_t m, input logic s, input logic c, input logic d,
                                   output logic we, output logic [13:0] w, output int nb,
                                   output logic ws, output int g);
    we = 1'b0; ws = 1'b0; w = m.sh; nb = m.bits; g = m.hi;
    if (s && !m.psck) begin
      if (c) m.edge_viol++;
      else begin m.sh = {m.sh[12:0], d}; m.bits++; end
    end
    if ((d !== m.pmosi) && !(m.psck && !s) && (c === m.pcs)) m.mosi_viol++;
    if (c && d) m.mosi_viol++;
    if (c && !m.pcs) begin we = 1'b1; w = m.sh; nb = m.bits; m.bits = 0; m.sh = '0; end
    if (!c && m.pcs) begin ws = 1'b1; g = m.hi; end
    m.hi = c ? m.hi + 1 : 0;
    m.psck = s; m.pcs = c; m.pmosi = d;
  endfunction

  always @(negedge clk) begin
    logic we, ws; logic [13:0] w; int nb, g;
    mon_step(m0, sck0, cs0, mosi0, we, w, nb, ws, g);
    if (we) begin words0.push_back(w); bits0.push_back(nb); end
    if (ws) gaps0.push_back(g);
  end

  always @(negedge clk) begin
    logic we, ws; logic [13:0] w; int nb, g;
    mon_step(m1, sck1, cs1, mosi1, we, w, nb, ws, g);
    if (we) begin words1.push_back(w); bits1.push_back(nb); end
    if (ws) gaps1.push_back(g);
  end

  // Drives one frame on dut0; returns cycles from first cs-low cycle to done (0 on timeout).
  task automatic drive_frame(input logic [13:0] a, input logic [13:0] b, input int extra_start_at,
                             output int len, output logic [2:0] first, output int wbase, output int gbase);
    int t;
    t = 0;
    while (ready0 !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    wbase = words0.size(); gbase = gaps0.size(); len = 0;
    start0 = 1'b1; sa0 = a; sb0 = b;
    @(negedge clk);
    start0 = 1'b0; sa0 = 14'($urandom); sb0 = 14'($urandom);
    first = {cs0, sck0, mosi0};
    for (int i = 1; i <= 2000; i++) begin
      start0 = (i == extra_start_at);
      @(negedge clk);
      if (done0 === 1'b1) begin len = i; break; end
    end
    start0 = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_checks++;
      if ({sck0, cs0, mosi0, ready0, done0} !== 5'b01010) begin
        n_fail++; $display("FAIL reset_idle0 cyc %0d: got %b expected 01010", i, {sck0, cs0, mosi0, ready0, done0});
      end
      n_checks++;
      if ({sck1, cs1, mosi1, ready1, done1} !== 5'b01010) begin
        n_fail++; $display("FAIL reset_idle1 cyc %0d: got %b expected 01010", i, {sck1, cs1, mosi1, ready1, done1});
      end
    end
  endtask

  task automatic test_frames();
    logic [13:0] pa[6], pb[6];
    int len, wb, gb; logic [2:0] first;
    pa[0] = 14'h1234; pb[0] = 14'h2ABC; pa[1] = 14'h3FFF; pb[1] = 14'h0000;
    for (int p = 2; p < 6; p++) begin pa[p] = 14'($urandom); pb[p] = 14'($urandom); end
    for (int p = 0; p < 6; p++) begin
      drive_frame(pa[p], pb[p], -1, len, first, wb, gb);
      n_checks++;
      if (first !== 3'b000) begin n_fail++; $display("FAIL frame%0d_first {cs,sck,mosi}: got %b expected 000", p, first); end
      n_checks++;
      if (len !== FRAME0) begin n_fail++; $display("FAIL frame%0d_len: got %0d expected %0d", p, len, FRAME0); end
      n_checks++;
      if (ready0 !== 1'b1) begin n_fail++; $display("FAIL frame%0d_ready_at_done: got %b expected 1", p, ready0); end
      n_checks++;
      if (words0.size() !== wb + 3) begin
        n_fail++; $display("FAIL frame%0d_word_count: got %0d expected 3", p, words0.size() - wb);
      end else begin
        for (int k = 0; k < 3; k++) begin
          n_checks++;
          if (words0[wb+k] !== exp_word(k, pa[p], pb[p])) begin
            n_fail++; $display("FAIL frame%0d_word%0d: got %h expected %h", p, k, words0[wb+k], exp_word(k, pa[p], pb[p]));
          end
          n_checks++;
          if (bits0[wb+k] !== 14) begin n_fail++; $display("FAIL frame%0d_edges%0d: got %0d expected 14", p, k, bits0[wb+k]); end
        end
      end
      if (gaps0.size() >= gb + 3) begin
        for (int k = 1; k < 3; k++) begin
          n_checks++;
          if (gaps0[gb+k] !== G0) begin n_fail++; $display("FAIL frame%0d_gap%0d: got %0d expected %0d", p, k, gaps0[gb+k], G0); end
        end
      end
      @(negedge clk);
      n_checks++;
      if (done0 !== 1'b0) begin n_fail++; $display("FAIL frame%0d_done_pulse: got %b expected 0", p, done0); end
    end
  endtask

  task automatic test_ignore_start();
    logic [13:0] a, b; int len, wb, gb, lows, dones; logic [2:0] first;
    a = 14'($urandom); b = 14'($urandom);
    drive_frame(a, b, 40, len, first, wb, gb);
    n_checks++;
    if (len !== FRAME0) begin n_fail++; $display("FAIL ignore_len: got %0d expected %0d", len, FRAME0); end
    n_checks++;
    if (words0.size() !== wb + 3) begin n_fail++; $display("FAIL ignore_word_count: got %0d expected 3", words0.size() - wb); end
    else begin
      n_checks++;
      if ({words0[wb+1], words0[wb+2]} !== {exp_word(1, a, b), exp_word(2, a, b)}) begin
        n_fail++; $display("FAIL ignore_words: got %h %h expected %h %h", words0[wb+1], words0[wb+2], exp_word(1, a, b), exp_word(2, a, b));
      end
    end
    lows = 0; dones = 0;
    repeat (300) begin @(negedge clk); if (cs0 !== 1'b1) lows++; if (done0 !== 1'b0) dones++; end
    n_checks++;
    if (lows + dones !== 0) begin n_fail++; $display("FAIL ignore_second_frame: got cs_low=%0d done=%0d expected 0 0", lows, dones); end
  endtask

  task automatic test_back_to_back();
    logic [13:0] a, b; int len, wb, gb; logic [2:0] first;
    drive_frame(14'($urandom), 14'($urandom), -1, len, first, wb, gb);
    n_checks++;
    if ({done0, ready0} !== 2'b11) begin n_fail++; $display("FAIL b2b_done_ready: got %b expected 11", {done0, ready0}); end
    a = 14'($urandom); b = 14'($urandom);
    drive_frame(a, b, -1, len, first, wb, gb);
    n_checks++;
    if (first !== 3'b000) begin n_fail++; $display("FAIL b2b_accept {cs,sck,mosi}: got %b expected 000", first); end
    n_checks++;
    if (len !== FRAME0) begin n_fail++; $display("FAIL b2b_len: got %0d expected %0d", len, FRAME0); end
    n_checks++;
    if (gaps0.size() < gb + 1 || gaps0[gb] !== G0 + 1) begin
      n_fail++; $display("FAIL b2b_cs_high: got %0d expected %0d", (gaps0.size() > gb) ? gaps0[gb] : -1, G0 + 1);
    end
    n_checks++;
    if (words0.size() !== wb + 3 || words0[wb+1] !== exp_word(1, a, b) || words0[wb+2] !== exp_word(2, a, b)) begin
      n_fail++; $display("FAIL b2b_words: got count %0d expected %h %h", words0.size() - wb, exp_word(1, a, b), exp_word(2, a, b));
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] a, b; int len, wb, gb, dones, lows; logic [2:0] first;
    while (ready0 !== 1'b1) @(negedge clk);
    start0 = 1'b1; sa0 = 14'($urandom); sb0 = 14'($urandom);
    @(negedge clk);
    start0 = 1'b0;
    repeat (70) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cs0, sck0, mosi0, ready0, done0} !== 5'b10010) begin
      n_fail++; $display("FAIL midreset_state {cs,sck,mosi,ready,done}: got %b expected 10010", {cs0, sck0, mosi0, ready0, done0});
    end
    rstn = 1'b1;
    dones = 0; lows = 0;
    repeat (200) begin @(negedge clk); if (done0 !== 1'b0) dones++; if (cs0 !== 1'b1) lows++; end
    n_checks++;
    if (dones + lows !== 0) begin n_fail++; $display("FAIL midreset_abort: got done=%0d cs_low=%0d expected 0 0", dones, lows); end
    a = 14'($urandom); b = 14'($urandom);
    drive_frame(a, b, -1, len, first, wb, gb);
    n_checks++;
    if (len !== FRAME0) begin n_fail++; $display("FAIL midreset_recover_len: got %0d expected %0d", len, FRAME0); end
    n_checks++;
    if (words0.size() !== wb + 3 || words0[wb] !== 14'h0FFF || words0[wb+1] !== exp_word(1, a, b) || words0[wb+2] !== exp_word(2, a, b)) begin
      n_fail++; $display("FAIL midreset_recover_words: got count %0d expected %h %h", words0.size() - wb, exp_word(1, a, b), exp_word(2, a, b));
    end
  endtask

  task automatic test_fast_config();
    logic [13:0] a, b; int len, wb, gb, stalls; logic pc, ps;
    for (int f = 0; f < 2; f++) begin
      a = 14'($urandom); b = 14'($urandom);
      while (ready1 !== 1'b1) @(negedge clk);
      wb = words1.size(); gb = gaps1.size(); len = 0; stalls = 0;
      start1 = 1'b1; sa1 = a; sb1 = b;
      @(negedge clk);
      start1 = 1'b0; sa1 = 14'($urandom); sb1 = 14'($urandom);
      n_checks++;
      if ({cs1, sck1, mosi1} !== 3'b000) begin n_fail++; $display("FAIL fast%0d_first: got %b expected 000", f, {cs1, sck1, mosi1}); end
      pc = cs1; ps = sck1;
      for (int i = 1; i <= 500; i++) begin
        @(negedge clk);
        if (!pc && !cs1 && sck1 === ps) stalls++;
        pc = cs1; ps = sck1;
        if (done1 === 1'b1) begin len = i; break; end
      end
      n_checks++;
      if (len !== FRAME1) begin n_fail++; $display("FAIL fast%0d_len: got %0d expected %0d", f, len, FRAME1); end
      n_checks++;
      if (stalls !== 0) begin n_fail++; $display("FAIL fast%0d_toggle: got %0d stalled cycles expected 0", f, stalls); end
      n_checks++;
      if (words1.size() !== wb + 3) begin
        n_fail++; $display("FAIL fast%0d_word_count: got %0d expected 3", f, words1.size() - wb);
      end else begin
        for (int k = 0; k < 3; k++) begin
          n_checks++;
          if (words1[wb+k] !== exp_word(k, a, b) || bits1[wb+k] !== 14) begin
            n_fail++; $display("FAIL fast%0d_word%0d: got %h/%0d edges expected %h/14", f, k, words1[wb+k], bits1[wb+k], exp_word(k, a, b));
          end
        end
      end
      n_checks++;
      if (gaps1.size() < gb + 3 || gaps1[gb+1] !== G1 || gaps1[gb+2] !== G1) begin
        n_fail++; $display("FAIL fast%0d_gap: got %0d entries expected gaps of %0d", f, gaps1.size() - gb, G1);
      end
    end
  endtask

  task automatic test_protocol();
    n_checks++;
    if (m0.edge_viol + m1.edge_viol !== 0) begin
      n_fail++; $display("FAIL sck_edge_with_cs_high: got %0d %0d expected 0 0", m0.edge_viol, m1.edge_viol);
    end
    n_checks++;
    if (m0.mosi_viol + m1.mosi_viol !== 0) begin
      n_fail++; $display("FAIL mosi_stability: got %0d %0d expected 0 0", m0.mosi_viol, m1.mosi_viol);
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_fast_config();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
